// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - shared program-counter constants and next-pc select encoding
package pc_unit_pkg;

    localparam int BUS_WIDTH_DEF    = 16;
    localparam int RESET_VECTOR_DEF = 0;
    localparam int PC_STEP_DEF      = 1;
    localparam int RAS_DEPTH_DEF    = 4;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_CALL = 3'd3,
        SEL_RET  = 3'd4,
        SEL_HOLD = 3'd5
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with wrapping top pointer
module pc_ras #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     swap,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    top_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             do_swap;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // A swap on an empty stack has nothing to replace, so it degrades to a push.
    assign do_push = push | (swap & empty);
    assign do_pop  = pop & ~empty;
    assign do_swap = swap & ~empty;

    assign overflow  = push & full;
    assign underflow = (pop | swap) & empty;

    assign dout = mem[top_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (do_push) begin
            top_ptr <= top_ptr + PTR_ONE;
            if (!full)
                count <= count + CNT_ONE;
        end else if (do_pop) begin
            top_ptr <= top_ptr - PTR_ONE;
            count   <= count - CNT_ONE;
        end
    end

    // When full, the slot after the top is the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (rst_n && do_push)
            mem[top_ptr + PTR_ONE] <= din;
        else if (rst_n && do_swap)
            mem[top_ptr] <= din;
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with branch/jump/call/return and return-address stack
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                   BUS_WIDTH    = BUS_WIDTH_DEF,
    parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = BUS_WIDTH'(RESET_VECTOR_DEF),
    parameter int                   PC_STEP      = PC_STEP_DEF,
    parameter int                   RAS_DEPTH    = RAS_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         branch_taken,
    input  logic [BUS_WIDTH-1:0]         branch_target,
    input  logic                         jump,
    input  logic                         call,
    input  logic                         ret,
    input  logic [BUS_WIDTH-1:0]         jump_target,
    output logic [BUS_WIDTH-1:0]         pc,
    output logic [BUS_WIDTH-1:0]         pc_plus,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    pc_sel_e              sel;
    logic [BUS_WIDTH-1:0] pc_next;
    logic [BUS_WIDTH-1:0] ras_top;
    logic                 ras_empty;
    logic                 ras_push;
    logic                 ras_pop;
    logic                 ras_swap;
    logic                 ovf_pulse;
    logic                 unf_pulse;

    assign pc_plus   = pc + BUS_WIDTH'(PC_STEP);
    assign ras_empty = (ras_count == '0);

    assign ras_push = ~stall & call & ~ret;
    assign ras_pop  = ~stall & ret & ~call;
    assign ras_swap = ~stall & ret & call;

    always_comb begin
        sel = SEL_SEQ;
        if (stall)
            sel = SEL_HOLD;
        else if (ret && !ras_empty)
            sel = SEL_RET;
        else if (call)
            sel = SEL_CALL;
        else if (jump)
            sel = SEL_JMP;
        else if (branch_taken)
            sel = SEL_BR;
    end

    always_comb begin
        pc_next = pc_plus;
        case (sel)
            SEL_HOLD: pc_next = pc;
            SEL_RET:  pc_next = ras_top;
            SEL_CALL: pc_next = jump_target;
            SEL_JMP:  pc_next = jump_target;
            SEL_BR:   pc_next = branch_target;
            default:  pc_next = pc_plus;
        endcase
    end

    pc_ras #(
        .WIDTH (BUS_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .swap      (ras_swap),
        .din       (pc_plus),
        .dout      (ras_top),
        .count     (ras_count),
        .overflow  (ovf_pulse),
        .underflow (unf_pulse)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc            <= RESET_VECTOR;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc <= pc_next;
            if (ovf_pulse)
                ras_overflow <= 1'b1;
            if (unf_pulse)
                ras_underflow <= 1'b1;
        end
    end

endmodule
